// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel filter and its output-side border padder:
// pixel width, pad state encoding and coordinate-width helpers.
package sobel_pkg;

    localparam int unsigned PIXEL_WIDTH = 8;

    typedef enum logic {
        S_BORDER   = 1'b0,
        S_INTERIOR = 1'b1
    } pad_state_t;

    // Coordinate counters must hold 0..n-1, and they never narrow below 1 bit.
    function automatic int unsigned coord_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned x_width(input int unsigned img_width);
        return coord_width(img_width);
    endfunction

    function automatic int unsigned y_width(input int unsigned img_height);
        return coord_width(img_height);
    endfunction

endpackage

// File: rtl/sobel_pad_raster_counter.sv
// Raster-order x/y coordinate counter with border, last-pixel and
// next-coordinate border classification.
module raster_counter
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH  = 720,
    parameter int unsigned HEIGHT = 540
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         advance,
    output logic [x_width(WIDTH)-1:0]    x,
    output logic [y_width(HEIGHT)-1:0]   y,
    output logic                         is_border,
    output logic                         is_last,
    output logic                         next_is_border
);

    localparam int unsigned XW = x_width(WIDTH);
    localparam int unsigned YW = y_width(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic          x_last;
    logic          y_last;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;

    always_comb begin
        x_last = (x == X_LAST);
        y_last = (y == Y_LAST);
        next_x = x_last ? '0 : x + XW'(1);
        next_y = y;
        if (x_last) begin
            next_y = y_last ? '0 : y + YW'(1);
        end
        is_border      = (x == '0) || x_last || (y == '0) || y_last;
        is_last        = x_last && y_last;
        next_is_border = (next_x == '0) || (next_x == X_LAST) ||
                         (next_y == '0) || (next_y == Y_LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= next_x;
            y <= next_y;
        end
    end

endmodule

// File: rtl/sobel_pad.sv
// Rebuilds full raster frames from the sobel interior-pixel FIFO by inserting
// a constant border ring. Optional frame_done pulse: SOBEL_PAD_FRAME_DONE_EN.
module sobel_pad
    import sobel_pkg::*;
#(
    parameter int unsigned          IMG_WIDTH    = 720,
    parameter int unsigned          IMG_HEIGHT   = 540,
    parameter int unsigned          DWIDTH       = PIXEL_WIDTH,
    parameter logic [DWIDTH-1:0]    BORDER_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              in_rd_en,
    input  logic [DWIDTH-1:0] in_dout,
    input  logic              in_empty,
    output logic              out_wr_en,
    output logic [DWIDTH-1:0] out_din,
    input  logic              out_full
`ifdef SOBEL_PAD_FRAME_DONE_EN
    ,
    output logic              frame_done
`endif
);

    localparam int unsigned XW = x_width(IMG_WIDTH);
    localparam int unsigned YW = y_width(IMG_HEIGHT);

    pad_state_t    state;
    pad_state_t    next_state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          is_border;
    logic          is_last;
    logic          next_is_border;

    raster_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT)
    ) u_raster_counter (
        .clock          (clock),
        .reset          (reset),
        .advance        (out_wr_en),
        .x              (x),
        .y              (y),
        .is_border      (is_border),
        .is_last        (is_last),
        .next_is_border (next_is_border)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_BORDER;
        end else begin
            state <= next_state;
        end
    end

    // Enables are qualified with reset so nothing is pushed or popped while held.
    always_comb begin
        out_din    = BORDER_VALUE;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        case (state)
            S_BORDER: begin
                out_wr_en = reset && !out_full;
            end
            S_INTERIOR: begin
                out_din   = in_dout;
                in_rd_en  = reset && !in_empty && !out_full;
                out_wr_en = reset && !in_empty && !out_full;
            end
            default: begin
                out_din = BORDER_VALUE;
            end
        endcase
        next_state = state;
        if (out_wr_en) begin
            next_state = next_is_border ? S_BORDER : S_INTERIOR;
        end
    end

`ifdef SOBEL_PAD_FRAME_DONE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_wr_en && is_last;
        end
    end
`else
    logic unused_is_last;
    assign unused_is_last = is_last;
`endif

    a_state_matches_coord: assert property (
        @(posedge clock) disable iff (!reset) ((state == S_BORDER) == is_border)
    );

    a_x_in_range: assert property (
        @(posedge clock) disable iff (!reset) ((32'(x) < IMG_WIDTH) && (32'(y) < IMG_HEIGHT))
    );

endmodule

// File: tb/tb_sobel_pad.sv
// Directed self-checking bench for sobel_pad on a 4x3 frame with a queue-modelled
// upstream FIFO; also checks frame_done when SOBEL_PAD_FRAME_DONE_EN is defined.
module tb_sobel_pad;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_rd_en;
    logic [7:0] in_dout;
    logic       in_empty;
    logic       out_wr_en;
    logic [7:0] out_din;
    logic       out_full;
`ifdef SOBEL_PAD_FRAME_DONE_EN
    logic       frame_done;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned pops     = 0;
    int unsigned pushes   = 0;
    int unsigned px       = 0;
    logic        exp_fd   = 1'b0;
    logic [7:0]  q[$];
    logic [7:0]  outq[$];
    logic [7:0]  expq[$];

    sobel_pad #(
        .IMG_WIDTH    (4),
        .IMG_HEIGHT   (3),
        .DWIDTH       (8),
        .BORDER_VALUE (8'h00)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .out_wr_en (out_wr_en),
        .out_din   (out_din),
        .out_full  (out_full)
`ifdef SOBEL_PAD_FRAME_DONE_EN
        ,
        .frame_done (frame_done)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic drive_in();
        in_empty = (q.size() == 0);
        in_dout  = (q.size() != 0) ? q[0] : 8'hEE;
    endtask

    // One clock cycle: sample at negedge, FIFO pop applied just after posedge.
    task automatic step();
        logic       wr;
        logic       rd;
        logic [7:0] d;
        @(negedge clock);
        wr = out_wr_en;
        rd = in_rd_en;
        d  = out_din;
`ifdef SOBEL_PAD_FRAME_DONE_EN
        check("frame_done", {31'b0, frame_done}, {31'b0, exp_fd});
`endif
        if (wr) begin
            outq.push_back(d);
            pushes++;
        end
        if (rd) pops++;
        exp_fd = wr && (px == 11);
        if (wr) px = (px == 11) ? 0 : px + 1;
        @(posedge clock);
        #1;
        if (rd && q.size() != 0) void'(q.pop_front());
        drive_in();
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        outq.delete();
        expq.delete();
        pops   = 0;
        pushes = 0;
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_len"}, outq.size(), expq.size());
        for (int unsigned i = 0; i < expq.size(); i++) begin
            if (i < outq.size()) check($sformatf("%s_w%0d", tag, i), {24'b0, outq[i]}, {24'b0, expq[i]});
        end
    endtask

    task automatic push_frame_exp(input logic [7:0] a, input logic [7:0] b);
        for (int unsigned i = 0; i < 5; i++) expq.push_back(8'h00);
        expq.push_back(a);
        expq.push_back(b);
        for (int unsigned i = 0; i < 5; i++) expq.push_back(8'h00);
    endtask

    initial begin
        reset    = 1'b0;
        out_full = 1'b0;
        drive_in();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("rst_rd_en", {31'b0, in_rd_en}, 32'd0);
        check("rst_din", {24'b0, out_din}, 32'h00);
`ifdef SOBEL_PAD_FRAME_DONE_EN
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
`endif
        reset = 1'b1;

        // Basic frame, no stalls
        clear_log();
        q = '{8'h11, 8'h22};
        drive_in();
        steps(12);
        push_frame_exp(8'h11, 8'h22);
        compare_out("basic");
        check("basic_pops", pops, 32'd2);
        check("basic_pushes", pushes, 32'd12);

        // Upstream empty: 5 border words then stall at (1,1)
        clear_log();
        steps(8);
        check("empty_pushes", pushes, 32'd5);
        check("empty_stall_rd", {31'b0, in_rd_en}, 32'd0);
        check("empty_stall_wr", {31'b0, out_wr_en}, 32'd0);
        q.push_back(8'h11);
        drive_in();
        step();
        check("empty_resume_pushes", pushes, 32'd6);
        q.push_back(8'h22);
        drive_in();
        steps(6);
        push_frame_exp(8'h11, 8'h22);
        compare_out("empty");
        check("empty_pops", pops, 32'd2);

        // Sink full for 10 cycles at (1,1)
        clear_log();
        q = '{8'h55, 8'h66};
        drive_in();
        steps(5);
        out_full = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            step();
            check("full_rd", {31'b0, in_rd_en}, 32'd0);
            check("full_wr", {31'b0, out_wr_en}, 32'd0);
        end
        check("full_qsize", q.size(), 32'd2);
        check("full_pushes", pushes, 32'd5);
        out_full = 1'b0;
        steps(7);
        push_frame_exp(8'h55, 8'h66);
        compare_out("full");

        // Two back-to-back frames
        clear_log();
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_in();
        steps(24);
        push_frame_exp(8'h11, 8'h22);
        push_frame_exp(8'h33, 8'h44);
        compare_out("b2b");
        check("b2b_pops", pops, 32'd4);

        // Reset asserted at (2,1)
        clear_log();
        q = '{8'h11, 8'h22, 8'h33};
        drive_in();
        steps(6);
        check("pre_rst_pushes", pushes, 32'd6);
        reset  = 1'b0;
        px     = 0;
        exp_fd = 1'b0;
        #1;
        check("midrst_wr", {31'b0, out_wr_en}, 32'd0);
        check("midrst_rd", {31'b0, in_rd_en}, 32'd0);
        steps(2);
        reset = 1'b1;
        clear_log();
        steps(12);
        push_frame_exp(8'h22, 8'h33);
        compare_out("after_rst");
        check("after_rst_pops", pops, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_pad.md
# sobel_pad

Output-side companion to the sobel filter. Drains the gradient FIFO the filter writes, which carries only the (IMG_WIDTH-2)·(IMG_HEIGHT-2) interior pixels of each frame in raster order. Rebuilds a full IMG_WIDTH×IMG_HEIGHT raster frame by inserting a constant border ring, and writes the result to the image-sink FIFO. Uses first-word-fall-through FIFO handshakes on both sides.

## Interface
- IMG_WIDTH, 720, frame width in pixels (≥3)
- IMG_HEIGHT, 540, frame height in pixels (≥3)
- DWIDTH, 8, pixel width
- BORDER_VALUE, 0, pixel value emitted on the border ring
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-low; block held in reset while 0
- in_rd_en  out  1  pops gradient FIFO; reset 0
- in_dout  in  DWIDTH  gradient FIFO head, valid while in_empty=0
- in_empty  in  1  gradient FIFO empty
- out_wr_en  out  1  pushes sink FIFO; reset 0
- out_din  out  DWIDTH  sink FIFO data; reset BORDER_VALUE
- out_full  in  1  sink FIFO full
- frame_done  out  1  present only with SOBEL_PAD_FRAME_DONE_EN; reset 0

## Operation
- Registered raster coordinates x ∈ [0, IMG_WIDTH-1] and y ∈ [0, IMG_HEIGHT-1]. Width is $clog2 of the dimension. Both reset to 0.
- Border: x==0 || x==IMG_WIDTH-1 || y==0 || y==IMG_HEIGHT-1. All other positions are interior.
- The state register holds the class of the current coordinate:
  - S_BORDER: reset state, since (0,0) is border.
  - S_INTERIOR
- Next state is computed from the advanced coordinate.
- S_BORDER:
  - out_din=BORDER_VALUE.
  - out_wr_en = !out_full.
  - in_rd_en=0. Input is never popped here, even when non-empty.
- S_INTERIOR:
  - out_din=in_dout.
  - in_rd_en = out_wr_en = !in_empty && !out_full. Pop and push always happen together.
- Advance: only on a cycle with out_wr_en=1.
  - x increments.
  - At x==IMG_WIDTH-1, x wraps to 0 and y increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0 and the next frame begins in S_BORDER.
- No pixel is dropped or duplicated. Each frame emits exactly IMG_WIDTH·IMG_HEIGHT words and consumes exactly (IMG_WIDTH-2)·(IMG_HEIGHT-2) words.
- Values pass through unmodified. No arithmetic on pixel data.

## Timing
- Zero-cycle latency. out_din and the enables are combinational from state, coordinates, in_dout, in_empty and out_full.
- All registers update on the rising clock edge.
- Stalls:
  - out_full=1 freezes all state in both classes.
  - in_empty=1 freezes all state in S_INTERIOR only. Border emission continues while upstream is empty.
- Simultaneous in_empty=0 and out_full=0 in S_INTERIOR give one pixel per cycle. Sustained throughput is 1 word/cycle.
- Reset mid-frame:
  - Coordinates return to (0,0) and state to S_BORDER; the partial frame is abandoned.
  - FIFOs are not flushed by this block. System reset is expected to cover them.
- Deasserting reset takes effect on the next rising edge.

## Configuration
- SOBEL_PAD_FRAME_DONE_EN defined:
  - Adds output frame_done.
  - It is a registered 1-cycle pulse in the cycle after the write of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
  - Reset value 0. Cleared by reset even mid-pulse.
- Not defined: port and logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package sobel_pkg:
  - pixel width constant (8)
  - state typedef with S_BORDER/S_INTERIOR
  - $clog2-based coordinate-width helpers, also used by the sobel filter
- One sub-module, raster_counter:
  - parameters WIDTH and HEIGHT
  - inputs: advance enable
  - outputs: x, y, is_border, is_last
- sobel_pad holds the FSM and handshake muxing.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=3, BORDER_VALUE=0, input 0x11,0x22, both FIFOs never stalling:
  - output is 00 00 00 00 00 11 22 00 00 00 00 00.
  - exactly 2 pops and 12 pushes.
- Same config, input FIFO empty throughout: the first 5 words (00) are written, then the block stalls at (1,1) with in_rd_en=0. Supplying 0x11 resumes output.
- out_full held high for 10 cycles mid-interior: in_rd_en=out_wr_en=0 and coordinates unchanged. No loss or duplication after release.
- Two back-to-back frames with inputs 0x11,0x22,0x33,0x44: second frame row 1 is 00 33 44 00, and the frame wrap is correct.
- reset=0 asserted at (2,1), then released: the next output is the (0,0) border word and the first pop takes the next FIFO word.
- With SOBEL_PAD_FRAME_DONE_EN: frame_done pulses exactly once per 12 writes, one cycle after the last write. It stays 0 after reset.
